mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port memory between two requesters: the instruction-fetch stage (IF, read-only) and the data-memory stage (DM, read/write). Each requester and the memory use a request/acknowledge handshake. DM has priority, and a streak counter bounds IF starvation. A timeout aborts any memory access that is never acknowledged.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_DM_STREAK, 4, max consecutive DM grants while IF is waiting (legal range 1..15)
TIMEOUT, 255, cycles to wait for mem_ack_i before abort; 0 disables timeout

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
if_req_i  in  1  IF read request, held until if_ack_o
if_addr_i  in  ADDR_W  IF address
if_ack_o  out  1  one-cycle IF completion pulse
if_data_o  out  DATA_W  IF read data, valid with if_ack_o
dm_req_i  in  1  DM request, held until dm_ack_o
dm_we_i  in  1  DM write enable (1 = write)
dm_addr_i  in  ADDR_W  DM address
dm_wdata_i  in  DATA_W  DM write data
dm_ack_o  out  1  one-cycle DM completion pulse
dm_data_o  out  DATA_W  DM read data, valid with dm_ack_o
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion
err_o  out  1  one-cycle pulse together with the ack of an aborted access
busy_o  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state=IDLE, streak=0, timer=0; every output is 0.
- Reset mid-transaction drops the transaction; no ack is issued.
- States: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE, grant decision, evaluated every cycle:
  - DM is granted if dm_req_i=1 and NOT (if_req_i=1 and streak==MAX_DM_STREAK).
  - Otherwise IF is granted if if_req_i=1.
  - Otherwise the block stays in IDLE.
- On grant:
  - Latch addr, we and wdata into mem_addr_o, mem_we_o, mem_wdata_o; set mem_req_o=1 on the next edge.
  - An IF grant forces mem_we_o=0.
  - Go to BUSY_IF or BUSY_DM; timer=0.
- Streak update at grant time:
  - DM grant with if_req_i=1: streak+1.
  - DM grant with if_req_i=0: streak=0.
  - IF grant: streak=0.
  - Streak saturates at MAX_DM_STREAK.
- BUSY_x: mem_req_o and the mem_* fields are held stable; timer increments each cycle.
  - mem_ack_i=1: mem_req_o<=0; x_ack_o<=1; x_data_o<=mem_rdata_i for reads only (unchanged for writes); go to RESP.
  - TIMEOUT!=0, timer==TIMEOUT-1 and mem_ack_i=0: mem_req_o<=0; x_ack_o<=1; err_o<=1; x_data_o unchanged; go to RESP.
  - If mem_ack_i and timeout expiry coincide, the ack wins and err_o=0.
- RESP lasts exactly one cycle:
  - x_ack_o (and err_o if set) is high; all acks and err_o clear on exit; go to IDLE.
  - Requests are not sampled in RESP. The requester must drop req_i before IDLE unless it is issuing a new request.
  - A req_i still high in IDLE is treated as a new request.
- mem_ack_i in IDLE or RESP is ignored.
- Request inputs are sampled only in IDLE. Changes to addr, data or we after the grant have no effect.
- Minimum turnaround: grant edge → mem_req_o (cycle 1) → mem_ack_i in cycle 1 → ack_o in cycle 2 → IDLE in cycle 3.
- if_ack_o and dm_ack_o are never high in the same cycle.

Test Plan:
1. Reset: assert rst_i while BUSY_DM with mem_req_o=1 → all outputs 0 in the same cycle; after release, no dm_ack_o until a new request.
2. IF read: addr 0x0000_0008; memory acks 3 cycles after mem_req_o with 0x0050_0093 → mem_we_o=0; if_ack_o high one cycle; if_data_o=0x0050_0093; busy_o low afterwards.
3. DM write: addr 0x10, wdata 0xDEAD_BEEF, we=1 → mem_we_o=1, mem_addr_o=0x10, mem_wdata_o=0xDEAD_BEEF; dm_ack_o pulse; dm_data_o unchanged; err_o=0.
4. Starvation bound, MAX_DM_STREAK=4: if_req_i and dm_req_i both held continuously, memory acks immediately → grant order DM,DM,DM,DM,IF,DM…; streak=0 after the IF grant.
5. Timeout, TIMEOUT=8: DM read with mem_ack_i tied 0 → exactly 8 cycles of mem_req_o=1, then dm_ack_o=1 and err_o=1 together for one cycle; then IDLE.
6. Ack/timeout collision and stray ack: mem_ack_i on the timeout cycle → err_o=0 and data captured. A mem_ack_i pulse while IDLE → no ack, no state change.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake and bus signal around mem_port_arbiter.
//   Requester IF : if_req_i, if_addr_i -> if_ack_o, if_data_o
//   Requester DM : dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i -> dm_ack_o, dm_data_o
//   Memory       : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o <- mem_rdata_i, mem_ack_i
//   Status       : err_o, busy_o
// The "slave" modport is the arbiter's view; "master" is the view of the
// surrounding requesters/memory (e.g. a testbench).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_data_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_ack_o;
    logic [DATA_W-1:0] dm_data_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    logic              err_o;
    logic              busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ack_i,
        output if_ack_o, if_data_o, dm_ack_o, dm_data_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output err_o, busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ack_i,
        input  if_ack_o, if_data_o, dm_ack_o, dm_data_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  err_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF, read
// only) and data memory (DM, read/write). DM wins ties, but after
// MAX_DM_STREAK consecutive DM grants with IF waiting, IF is served once.
// A memory access not acknowledged within TIMEOUT cycles is aborted and
// completed with err_o (TIMEOUT = 0 waits forever).
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    mem_port_arbiter_if.slave (requester, memory and status signals);
//          its ADDR_W/DATA_W must match this module's parameters.
// All outputs are registered.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = 4;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [SW-1:0]     streak_q, streak_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] dm_data_q, dm_data_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic grant_dm, grant_if, timeout_hit, done;

    always_comb begin
        grant_dm    = bus.dm_req_i &&
                      !(bus.if_req_i && (streak_q == SW'(MAX_DM_STREAK)));
        grant_if    = !grant_dm && bus.if_req_i;
        timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));
        // A memory ack on the last allowed cycle completes normally.
        done        = bus.mem_ack_i || timeout_hit;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_dm)      state_d = BUSY_DM;
                else if (grant_if) state_d = BUSY_IF;
            end
            BUSY_IF, BUSY_DM: begin
                if (done) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of every registered output and of the streak/timer state.
    always_comb begin
        streak_d    = streak_q;
        timer_d     = timer_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = 1'b0;
        if_data_d   = if_data_q;
        dm_data_d   = dm_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = (state_d != IDLE);

        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we_i;
                    mem_addr_d  = bus.dm_addr_i;
                    mem_wdata_d = bus.dm_wdata_i;
                    timer_d     = '0;
                    if (!bus.if_req_i)
                        streak_d = '0;
                    else if (streak_q != SW'(MAX_DM_STREAK))
                        streak_d = streak_q + 1'b1;
                end else if (grant_if) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr_i;
                    timer_d    = '0;
                    streak_d   = '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                timer_d = timer_q + 1'b1;
                if (done) begin
                    mem_req_d = 1'b0;
                    err_d     = !bus.mem_ack_i;
                    if (state_q == BUSY_IF) begin
                        if_ack_d = 1'b1;
                        if (bus.mem_ack_i) if_data_d = bus.mem_rdata_i;
                    end else begin
                        dm_ack_d = 1'b1;
                        if (bus.mem_ack_i && !mem_we_q) dm_data_d = bus.mem_rdata_i;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            streak_q    <= '0;
            timer_q     <= '0;
            if_ack_q    <= 1'b0;
            if_data_q   <= '0;
            dm_ack_q    <= 1'b0;
            dm_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            streak_q    <= streak_d;
            timer_q     <= timer_d;
            if_ack_q    <= if_ack_d;
            if_data_q   <= if_data_d;
            dm_ack_q    <= dm_ack_d;
            dm_data_q   <= dm_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_ack_o    = if_ack_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.dm_ack_o    = dm_ack_q;
    assign bus.dm_data_o   = dm_data_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.err_o       = err_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MAX_DM_STREAK=4, TIMEOUT=8).
// The bench plays both requesters and the memory; a transaction-level model
// (pending requests, streak count, word-array memory) predicts grants,
// completion latency, error flag and returned data.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic clk;
    logic rst;

    int total  = 0;
    int passes = 0;

    logic [31:0] mem [16];
    logic [31:0] exp_if_data;
    logic [31:0] exp_dm_data;
    int          streak_m;

    logic        if_pend, dm_pend, dm_w;
    logic [31:0] if_a, dm_a, dm_d;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DM_STREAK(MAXS),
        .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic apply();
        bus.if_req_i   = if_pend;
        bus.if_addr_i  = if_a;
        bus.dm_req_i   = dm_pend;
        bus.dm_we_i    = dm_w;
        bus.dm_addr_i  = dm_a;
        bus.dm_wdata_i = dm_d;
    endtask

    task automatic new_if();
        if_a = 32'($urandom_range(0, 15)) << 2;
    endtask

    task automatic new_dm();
        dm_a = 32'($urandom_range(0, 15)) << 2;
        dm_w = 1'($urandom_range(0, 1));
        dm_d = $urandom;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_if_ack"}, 32'(bus.if_ack_o), 0);
        chk({tag, "_dm_ack"}, 32'(bus.dm_ack_o), 0);
        chk({tag, "_err"}, 32'(bus.err_o), 0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 0);
        chk({tag, "_mem_req"}, 32'(bus.mem_req_o), 0);
    endtask

    // Called at an IDLE sample point with the requests applied; returns at
    // the sample point of the response cycle.
    task automatic complete(input logic g_dm, input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input int lat, input bit scramble);
        int n;
        int k;
        int exp_n;
        logic exp_err;
        logic [31:0] rd;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.mem_req_o && n < 4);
        chk("grant_latency", 32'(n), 1);
        chk("mem_we", 32'(bus.mem_we_o), 32'(we));
        chk("mem_addr", bus.mem_addr_o, a);
        if (we) chk("mem_wdata", bus.mem_wdata_o, wd);
        chk("busy_on", 32'(bus.busy_o), 1);
        if (scramble) begin
            if (g_dm) begin
                bus.dm_addr_i  = $urandom;
                bus.dm_wdata_i = $urandom;
                bus.dm_we_i    = ~we;
            end else begin
                bus.if_addr_i = $urandom;
            end
        end
        exp_err = (lat >= TMO);
        exp_n   = exp_err ? TMO : lat + 1;
        rd      = we ? $urandom : mem[a[5:2]];
        k = 0;
        forever begin
            if (k == lat) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = rd;
            end else begin
                bus.mem_rdata_i = $urandom;
            end
            tick();
            k++;
            bus.mem_ack_i = 1'b0;
            if (bus.if_ack_o || bus.dm_ack_o || k >= 40) break;
            chk("req_held", 32'(bus.mem_req_o), 1);
            chk("addr_held", bus.mem_addr_o, a);
        end
        chk("ack_cycles", 32'(k), 32'(exp_n));
        chk("if_ack", 32'(bus.if_ack_o), 32'(!g_dm));
        chk("dm_ack", 32'(bus.dm_ack_o), 32'(g_dm));
        chk("err", 32'(bus.err_o), 32'(exp_err));
        chk("req_dropped", 32'(bus.mem_req_o), 0);
        chk("busy_resp", 32'(bus.busy_o), 1);
        if (!exp_err) begin
            if (g_dm && we) mem[a[5:2]] = wd;
            else if (g_dm)  exp_dm_data = rd;
            else            exp_if_data = rd;
        end
        chk("if_data", bus.if_data_o, exp_if_data);
        chk("dm_data", bus.dm_data_o, exp_dm_data);
    endtask

    // Arbitration rule applied to the pending requests, then one transaction.
    task automatic step(input int lat, input bit scramble, output logic g);
        g = dm_pend && !(if_pend && streak_m == MAXS);
        if (g) streak_m = if_pend ? ((streak_m < MAXS) ? streak_m + 1 : streak_m) : 0;
        else   streak_m = 0;
        complete(g, g ? dm_a : if_a, g ? dm_w : 1'b0, dm_d, lat, scramble);
    endtask

    task automatic finish_resp(input string tag);
        apply();
        tick();
        chk_quiet(tag);
    endtask

    initial begin
        logic g;
        int   v;
        int   seen;
        rst = 1'b1;
        if_pend = 0; dm_pend = 0; dm_w = 0;
        if_a = '0; dm_a = '0; dm_d = '0;
        apply();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        exp_if_data = '0;
        exp_dm_data = '0;
        streak_m    = 0;
        tick();
        tick();
        chk_quiet("reset");
        chk("reset_if_data", bus.if_data_o, 0);
        chk("reset_dm_data", bus.dm_data_o, 0);
        chk("reset_mem_addr", bus.mem_addr_o, 0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a DM read drops it.
        dm_pend = 1; dm_w = 0; dm_a = 32'h20;
        apply();
        tick();
        chk("pre_rst_req", 32'(bus.mem_req_o), 1);
        #3 rst = 1'b1;
        #1;
        chk_quiet("async_rst");
        chk("async_rst_addr", bus.mem_addr_o, 0);
        dm_pend = 0;
        apply();
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.dm_ack_o || bus.if_ack_o || bus.mem_req_o) seen++;
        end
        chk("no_ack_after_rst", 32'(seen), 0);

        // IF read of 0x8, ack three cycles after the request.
        mem[2] = 32'h0050_0093;
        if_pend = 1; if_a = 32'h8;
        apply();
        step(3, 0, g);
        chk("if_read_data", bus.if_data_o, 32'h0050_0093);
        if_pend = 0;
        finish_resp("if_read_idle");

        // DM write; inputs scrambled after grant must not leak through.
        dm_pend = 1; dm_w = 1; dm_a = 32'h10; dm_d = 32'hDEAD_BEEF;
        apply();
        step(1, 1, g);
        dm_pend = 0;
        finish_resp("dm_write_idle");

        // DM read with no memory ack: timeout after 8 request cycles.
        dm_pend = 1; dm_w = 0; dm_a = 32'h24;
        apply();
        step(100, 0, g);
        dm_pend = 0;
        finish_resp("timeout_idle");

        // Memory ack on the final allowed cycle beats the timeout.
        dm_pend = 1; dm_w = 0; dm_a = 32'h10;
        apply();
        step(TMO - 1, 0, g);
        chk("collision_data", bus.dm_data_o, 32'hDEAD_BEEF);
        dm_pend = 0;
        finish_resp("collision_idle");

        // Stray memory ack while idle is ignored.
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h1234_5678;
        tick();
        bus.mem_ack_i = 1'b0;
        chk_quiet("stray_ack");
        tick();
        chk_quiet("stray_ack2");
        chk("stray_dm_data", bus.dm_data_o, 32'hDEAD_BEEF);

        // Both requesters held: IF gets through after four DM grants.
        if_pend = 1; if_a = 32'h4;
        dm_pend = 1; dm_w = 0; dm_a = 32'h30;
        apply();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, g);
            chk("starve_order", 32'(g), 32'((i % 5) != 4));
            finish_resp("starve_idle");
        end
        if_pend = 0; dm_pend = 0;
        apply();
        tick();

        // Random traffic with random memory latency, including timeouts.
        for (int r = 0; r < 80; r++) begin
            if (!if_pend && !dm_pend) begin
                v = $urandom_range(1, 3);
                if_pend = v[0];
                dm_pend = v[1];
                if (if_pend) new_if();
                if (dm_pend) new_dm();
                apply();
            end
            step($urandom_range(0, 9), 1, g);
            if (g) begin
                dm_pend = 1'($urandom_range(0, 1));
                if (dm_pend) new_dm();
            end else begin
                if_pend = 1'($urandom_range(0, 1));
                if (if_pend) new_if();
            end
            finish_resp("rand_idle");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
